// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op-code and FSM encodings for the EX-stage ALU; the ID-stage decoder
// imports the same package so both sides agree on op_i values.
package alu_muldiv_seq_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] ALU_AND  = 4'd0;
   localparam logic [OP_W-1:0] ALU_OR   = 4'd1;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'd2;
   localparam logic [OP_W-1:0] ALU_ADD  = 4'd3;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'd4;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;
   localparam logic [OP_W-1:0] ALU_MUL  = 4'd10;
   localparam logic [OP_W-1:0] ALU_DIV  = 4'd11;
   localparam logic [OP_W-1:0] ALU_REM  = 4'd12;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      MD_MUL,
      MD_DIV,
      MD_REM
   } md_op_e;

   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   function automatic md_op_e to_md(input logic [OP_W-1:0] op);
      case (op)
         ALU_DIV: return MD_DIV;
         ALU_REM: return MD_REM;
         default: return MD_MUL;
      endcase
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide on operand
// magnitudes; one step per cycle for XLEN cycles after start_i.
module alu_iter_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic            mul_i,
   input  logic [XLEN-1:0] mag_a_i,
   input  logic [XLEN-1:0] mag_b_i,
   output logic            done_o,
   output logic [XLEN-1:0] prod_rem_o,
   output logic [XLEN-1:0] quo_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  acc_q, acc_d;   // product accumulator / partial remainder
   logic [XLEN-1:0]  sh_q, sh_d;     // multiplier / dividend-becoming-quotient
   logic [XLEN-1:0]  m_q, m_d;       // multiplicand / divisor
   logic             mul_q, mul_d;
   logic [XLEN:0]    rem_sh, diff;

   // NOTE: every signal assigned below gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      sh_d   = sh_q;
      m_d    = m_q;
      mul_d  = mul_q;
      rem_sh = {acc_q, sh_q[XLEN-1]};
      diff   = rem_sh - {1'b0, m_q};
      if (start_i) begin
         cnt_d = CNT_W'(XLEN);
         acc_d = '0;
         sh_d  = mul_i ? mag_b_i : mag_a_i;
         m_d   = mul_i ? mag_a_i : mag_b_i;
         mul_d = mul_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (mul_q) begin
            if (sh_q[0]) acc_d = acc_q + m_q;
            m_d  = m_q << 1;
            sh_d = sh_q >> 1;
         end else if (!diff[XLEN]) begin
            acc_d = diff[XLEN-1:0];
            sh_d  = {sh_q[XLEN-2:0], 1'b1};
         end else begin
            acc_d = rem_sh[XLEN-1:0];
            sh_d  = {sh_q[XLEN-2:0], 1'b0};
         end
      end
      if (flush_i) cnt_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // NOTE: datapath registers are deliberately not reset; they are only consumed while the counter runs.
   always_ff @(posedge clk_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      m_q   <= m_d;
      mul_q <= mul_d;
   end

   // The final step's result is offered combinationally so the top can register it on the same edge.
   assign done_o     = (cnt_q == CNT_W'(1));
   assign prod_rem_o = acc_d;
   assign quo_o      = sh_d;

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU: single-cycle ops and divide fast paths registered in one cycle,
// MUL/DIV/REM via the iterative unit with a fixed XLEN-cycle BUSY phase.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = OP_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              flush_i,
   input  logic [CTRL_W-1:0] op_i,
   input  logic [XLEN-1:0]   data1_i,
   input  logic [XLEN-1:0]   data2_i,
   output logic              valid_o,
   output logic [XLEN-1:0]   data_o,
   output logic              busy_o
);

   localparam int SHAMT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            valid_q, valid_d;
   md_op_e          md_q, md_d;
   logic            neg_q, neg_d;

   logic [SHAMT_W-1:0] shamt;
   logic               sign_a, sign_b;
   logic [XLEN-1:0]    mag_a, mag_b;
   logic               div_zero, div_ovf, fast, accept, start;
   logic [XLEN-1:0]    alu_res, iter_mag, iter_res;
   logic               iter_done;
   logic [XLEN-1:0]    iter_prod_rem, iter_quo;

   assign shamt    = data2_i[SHAMT_W-1:0];
   assign sign_a   = data1_i[XLEN-1];
   assign sign_b   = data2_i[XLEN-1];
   assign mag_a    = sign_a ? -data1_i : data1_i;
   assign mag_b    = sign_b ? -data2_i : data2_i;
   assign div_zero = (data2_i == '0);
   assign div_ovf  = (data1_i == MIN_VAL) && (data2_i == '1);
   assign fast     = ((op_i == ALU_DIV) || (op_i == ALU_REM)) && (div_zero || div_ovf);
   assign ready_o  = (state_q != ST_BUSY);
   assign busy_o   = (state_q == ST_BUSY);
   assign accept   = valid_i && ready_o && !flush_i;
   assign start    = accept && is_muldiv(op_i) && !fast;

   always_comb begin
      alu_res = '0;
      case (op_i)
         ALU_AND:  alu_res = data1_i & data2_i;
         ALU_OR:   alu_res = data1_i | data2_i;
         ALU_XOR:  alu_res = data1_i ^ data2_i;
         ALU_ADD:  alu_res = data1_i + data2_i;
         ALU_SUB:  alu_res = data1_i - data2_i;
         ALU_SLL:  alu_res = data1_i << shamt;
         ALU_SRL:  alu_res = data1_i >> shamt;
         ALU_SRA:  alu_res = XLEN'($signed(data1_i) >>> shamt);
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, data1_i < data2_i};
         // Only reached on the divide fast paths: zero divisor or MIN / -1.
         ALU_DIV:  alu_res = div_zero ? '1 : MIN_VAL;
         ALU_REM:  alu_res = div_zero ? data1_i : '0;
         default:  alu_res = '0;
      endcase
   end

   alu_iter_muldiv #(.XLEN(XLEN)) u_iter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .start_i    (start),
      .mul_i      (op_i == ALU_MUL),
      .mag_a_i    (mag_a),
      .mag_b_i    (mag_b),
      .done_o     (iter_done),
      .prod_rem_o (iter_prod_rem),
      .quo_o      (iter_quo)
   );

   assign iter_mag = (md_q == MD_DIV) ? iter_quo : iter_prod_rem;
   assign iter_res = neg_q ? -iter_mag : iter_mag;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = 1'b0;
      md_d    = md_q;
      neg_d   = neg_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_BUSY) begin
         if (iter_done) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            data_d  = iter_res;
         end
      end else begin
         state_d = ST_IDLE;
         if (start) begin
            state_d = ST_BUSY;
            md_d    = to_md(op_i);
            // Remainder takes the dividend's sign; product and quotient take the xor.
            neg_d   = (op_i == ALU_REM) ? sign_a : (sign_a ^ sign_b);
         end else if (accept) begin
            valid_d = 1'b1;
            data_d  = alu_res;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         md_q    <= MD_MUL;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         md_q    <= md_d;
         neg_q   <= neg_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq: stimulus pushes hand-computed
// results with their expected arrival cycle; a negedge monitor pops and compares.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i, valid_i, flush_i;
   logic [3:0]  op_i;
   logic [31:0] data1_i, data2_i;
   logic        ready_o, valid_o, busy_o;
   logic [31:0] data_o;

   alu_muldiv_seq #(.XLEN(32), .CTRL_W(4)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .flush_i (flush_i),
      .op_i    (op_i),
      .data1_i (data1_i),
      .data2_i (data2_i),
      .valid_o (valid_o),
      .data_o  (data_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] data;
      int          cycle;
   } exp_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] last_res = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (valid_o) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check(e.name, data_o, e.data);
            check({e.name, "_cycle"}, cyc, e.cycle);
            last_res = e.data;
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name, input bit push);
      check({name, "_ready"}, {31'd0, ready_o}, 32'd1);
      valid_i = 1'b1;
      op_i    = op;
      data1_i = a;
      data2_i = b;
      if (push) sb.push_back('{name, exp, cyc + lat});
      @(posedge clk_i); #1;
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic send_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
      send(op, a, b, exp, 33, name, 1'b1);
      idle(32);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
      check("scoreboard_drained", sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int low, bad;
      rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
      op_i = '0; data1_i = '0; data2_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_busy",  {31'd0, busy_o},  32'd0);
      check("rst_data",  data_o, 32'd0);
      rst_i = 1'b0;
      idle(1);

      // Back-to-back single-cycle ops: one result per cycle, ready never drops.
      send(ALU_ADD,  32'd7,        32'hFFFF_FFF7, 32'hFFFF_FFFE, 1, "add_7_m9", 1'b1);
      send(ALU_SRA,  32'h8000_0000, 32'd36,       32'hF800_0000, 1, "sra_shamt4", 1'b1);
      send(ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, "and", 1'b1);
      send(ALU_OR,   32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1, "or", 1'b1);
      send(ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, "xor", 1'b1);
      send(ALU_SUB,  32'd0,        32'd1,        32'hFFFF_FFFF, 1, "sub_wrap", 1'b1);
      send(ALU_ADD,  32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 1, "add_wrap", 1'b1);
      send(ALU_SLL,  32'd1,        32'd31,       32'h8000_0000, 1, "sll_31", 1'b1);
      send(ALU_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000, 1, "srl_4", 1'b1);
      send(ALU_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1,         1, "slt_signed", 1'b1);
      send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0,         1, "sltu_unsigned", 1'b1);
      send(4'd15,    32'd5,        32'd6,        32'd0,         1, "undef_op", 1'b1);
      idle(2);

      // MUL: ready low for exactly 32 cycles, result after 33.
      send(ALU_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33, "mul_m3_5", 1'b1);
      low = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (!ready_o) low++;
         if (busy_o !== !ready_o) bad++;
         idle(1);
      end
      check("mul_ready_low_cycles", low, 32'd32);
      check("busy_is_not_ready", bad, 32'd0);

      // Each following op is accepted in the DONE cycle of the previous one.
      send(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2", 1'b1);
      idle(32);
      send_md(ALU_REM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
      send_md(ALU_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
      send_md(ALU_DIV, 32'd100,       32'd7,         32'd14,        "div_100_7");
      send_md(ALU_REM, 32'd100,       32'hFFFF_FFF9, 32'd2,         "rem_100_m7");
      send_md(ALU_REM, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, "rem_m100_7");
      send_md(ALU_MUL, 32'd0,         32'd1234,      32'd0,         "mul_zero");
      send_md(ALU_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mul_min_m1");
      send(ALU_ADD, 32'd1, 32'd2, 32'd3, 1, "add_in_done", 1'b1);

      // Divide fast paths complete in one cycle.
      send(ALU_DIV, 32'd123,        32'd0,         32'hFFFF_FFFF, 1, "div_by_zero", 1'b1);
      send(ALU_REM, 32'd5,          32'd0,         32'd5,         1, "rem_by_zero", 1'b1);
      send(ALU_DIV, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b1);
      send(ALU_REM, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, "rem_ovf", 1'b1);
      send(ALU_ADD, 32'h0000_1234,  32'h0000_1111, 32'h0000_2345, 1, "add_pre_flush", 1'b1);
      idle(2);

      // Flush at BUSY cycle 5: no result, ready next cycle, data held.
      send(ALU_DIV, 32'd1000, 32'd3, 32'd0, 0, "div_flushed", 1'b0);
      idle(4);
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      check("flush_ready", {31'd0, ready_o}, 32'd1);
      check("flush_valid", {31'd0, valid_o}, 32'd0);
      check("flush_data_held", data_o, last_res);
      idle(40);
      send(ALU_ADD, 32'd1, 32'd1, 32'd2, 1, "add_after_flush", 1'b1);
      idle(2);

      // Flush with valid_i high in IDLE: nothing is accepted.
      valid_i = 1'b1; op_i = ALU_ADD; data1_i = 32'd5; data2_i = 32'd5; flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      check("flush_idle_valid", {31'd0, valid_o}, 32'd0);
      check("flush_idle_data", data_o, 32'd2);
      idle(3);

      // Flush in the last BUSY cycle suppresses the DONE pulse.
      send(ALU_DIV, 32'd50, 32'd5, 32'd0, 0, "div_flush_last", 1'b0);
      idle(31);
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      check("flush_last_valid", {31'd0, valid_o}, 32'd0);
      check("flush_last_data", data_o, 32'd2);
      idle(5);

      // Reset mid-MUL: outputs return to reset values, no late result.
      send(ALU_MUL, 32'd3, 32'd3, 32'd0, 0, "mul_reset", 1'b0);
      idle(10);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("midrst_ready", {31'd0, ready_o}, 32'd1);
      check("midrst_valid", {31'd0, valid_o}, 32'd0);
      check("midrst_busy",  {31'd0, busy_o},  32'd0);
      check("midrst_data",  data_o, 32'd0);
      idle(40);

      // valid_i held through BUSY must not produce a second accept.
      send(ALU_MUL, 32'd6, 32'd7, 32'd42, 33, "mul_held_valid", 1'b1);
      repeat (20) begin
         @(posedge clk_i); #1;
      end
      idle(20);

      drain();
      idle(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
